// File: rtl/sysbus_arbiter.sv
// Two-requester (fetch / data memory) arbiter for the single Sysbus master port.
// Define SYSBUS_ARB_RR_EN for round-robin tie-breaking; otherwise data memory has fixed priority.
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      if_valid,
    input  logic [BUS_DATA_WIDTH-1:0] if_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  if_tag,
    output logic                      if_accept,
    output logic                      if_rvalid,
    output logic                      if_rlast,

    input  logic                      dm_valid,
    input  logic [BUS_DATA_WIDTH-1:0] dm_addr,
    input  logic [BUS_TAG_WIDTH-1:0]  dm_tag,
    output logic                      dm_accept,
    output logic                      dm_rvalid,
    output logic                      dm_rlast,

    output logic [BUS_DATA_WIDTH-1:0] rdata,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    state_t                      state, state_nx;
    owner_t                      owner, owner_nx;
    logic [CNT_W-1:0]            beat_cnt, beat_cnt_nx;
    logic                        reqcyc_nx;
    logic [BUS_DATA_WIDTH-1:0]   req_nx;
    logic [BUS_TAG_WIDTH-1:0]    reqtag_nx;
    logic                        if_accept_nx, dm_accept_nx;
    logic                        pick_if, pick_dm;
    logic                        arb_open;
    logic                        fwd;
    logic                        last_beat;
`ifdef SYSBUS_ARB_RR_EN
    owner_t                      last_grant, last_grant_nx;
`endif

    // Routing uses the latched owner, so the response tag carries no information here.
    logic unused_resptag;
    assign unused_resptag = ^bus_resptag;

    always_comb begin
`ifdef SYSBUS_ARB_RR_EN
        pick_dm = dm_valid && (!if_valid || last_grant == OWN_IF);
`else
        pick_dm = dm_valid;
`endif
        pick_if = if_valid && !pick_dm;
    end

    // Response path is combinational from the bus, gated so nothing leaks out in IDLE/REQ or under reset.
    always_comb begin
        fwd         = !reset && (state == ST_WAIT || state == ST_RESP) && bus_respcyc;
        last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
        if_rvalid   = fwd && (owner == OWN_IF);
        dm_rvalid   = fwd && (owner == OWN_DM);
        if_rlast    = if_rvalid && last_beat;
        dm_rlast    = dm_rvalid && last_beat;
        bus_respack = fwd;
        rdata       = fwd ? bus_resp : '0;
    end

    always_comb begin
        // NOTE: every next-state variable gets its hold value first so no path through the case infers a latch.
        state_nx     = state;
        owner_nx     = owner;
        beat_cnt_nx  = beat_cnt;
        reqcyc_nx    = bus_reqcyc;
        req_nx       = bus_req;
        reqtag_nx    = bus_reqtag;
        if_accept_nx = 1'b0;
        dm_accept_nx = 1'b0;
        arb_open     = 1'b0;
`ifdef SYSBUS_ARB_RR_EN
        last_grant_nx = last_grant;
`endif

        case (state)
            ST_IDLE: arb_open = 1'b1;

            ST_REQ: begin
                if (bus_reqack) begin
                    reqcyc_nx    = 1'b0;
                    req_nx       = '0;
                    reqtag_nx    = '0;
                    if_accept_nx = (owner == OWN_IF);
                    dm_accept_nx = (owner == OWN_DM);
                    state_nx     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus_respcyc) begin
                    state_nx    = ST_RESP;
                    beat_cnt_nx = beat_cnt + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (bus_respcyc) begin
                    if (beat_cnt != CNT_W'(BEATS))
                        beat_cnt_nx = beat_cnt + CNT_W'(1);
                end else begin
                    state_nx    = ST_IDLE;
                    owner_nx    = OWN_NONE;
                    beat_cnt_nx = '0;
                    arb_open    = 1'b1;
                end
            end

            default: begin
                state_nx = ST_IDLE;
                owner_nx = OWN_NONE;
            end
        endcase

        // The burst-end cycle also arbitrates, so a waiting requester is granted without an idle bubble.
        if (arb_open && (pick_if || pick_dm)) begin
            state_nx  = ST_REQ;
            reqcyc_nx = 1'b1;
            owner_nx  = pick_dm ? OWN_DM : OWN_IF;
            req_nx    = pick_dm ? dm_addr : if_addr;
            reqtag_nx = pick_dm ? dm_tag : if_tag;
`ifdef SYSBUS_ARB_RR_EN
            last_grant_nx = pick_dm ? OWN_DM : OWN_IF;
`endif
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            beat_cnt   <= '0;
            bus_reqcyc <= 1'b0;
            bus_req    <= '0;
            bus_reqtag <= '0;
            if_accept  <= 1'b0;
            dm_accept  <= 1'b0;
`ifdef SYSBUS_ARB_RR_EN
            last_grant <= OWN_IF;
`endif
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            beat_cnt   <= beat_cnt_nx;
            bus_reqcyc <= reqcyc_nx;
            bus_req    <= req_nx;
            bus_reqtag <= reqtag_nx;
            if_accept  <= if_accept_nx;
            dm_accept  <= dm_accept_nx;
`ifdef SYSBUS_ARB_RR_EN
            last_grant <= last_grant_nx;
`endif
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed testbench for sysbus_arbiter: request handshake, burst routing, arbitration,
// mid-transaction reset, short/long bursts and spurious bus handshakes.
module tb_sysbus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_valid, dm_valid;
    logic [DW-1:0] if_addr, dm_addr;
    logic [TW-1:0] if_tag, dm_tag;
    logic          if_accept, if_rvalid, if_rlast;
    logic          dm_accept, dm_rvalid, dm_rlast;
    logic [DW-1:0] rdata;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack, bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;

    int checks = 0;
    int errors = 0;

    sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_addr(if_addr), .if_tag(if_tag),
        .if_accept(if_accept), .if_rvalid(if_rvalid), .if_rlast(if_rlast),
        .dm_valid(dm_valid), .dm_addr(dm_addr), .dm_tag(dm_tag),
        .dm_accept(dm_accept), .dm_rvalid(dm_rvalid), .dm_rlast(dm_rlast),
        .rdata(rdata),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_resptag(bus_resptag), .bus_respack(bus_respack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [2*DW+2*TW+9:0] all_outputs();
        return {if_accept, if_rvalid, if_rlast, dm_accept, dm_rvalid, dm_rlast,
                rdata, bus_reqcyc, bus_req, bus_reqtag, bus_respack, bus_respack, bus_respack, bus_respack};
    endfunction

    task automatic clear_inputs();
        if_valid = 0; if_addr = '0; if_tag = '0;
        dm_valid = 0; dm_addr = '0; dm_tag = '0;
        bus_reqack = 0; bus_respcyc = 0; bus_resp = '0; bus_resptag = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    // Called one cycle before the grant is visible; walks REQ for 'hold' cycles, then the accept pulse.
    task automatic req_phase(input bit is_dm, input logic [DW-1:0] addr, input logic [TW-1:0] tag, input int hold);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (k == hold - 1) bus_reqack = 1;
            #1;
            checks++;
            if (bus_reqcyc !== 1'b1) begin
                errors++; $display("FAIL req_reqcyc cyc%0d: got %b expected 1", k, bus_reqcyc);
            end
            checks++;
            if (bus_req !== addr) begin
                errors++; $display("FAIL req_addr cyc%0d: got %h expected %h", k, bus_req, addr);
            end
            checks++;
            if (bus_reqtag !== tag) begin
                errors++; $display("FAIL req_tag cyc%0d: got %h expected %h", k, bus_reqtag, tag);
            end
            checks++;
            if ({if_accept, dm_accept} !== 2'b00) begin
                errors++; $display("FAIL req_early_accept cyc%0d: got %b expected 00", k, {if_accept, dm_accept});
            end
        end
        @(negedge clk);
        bus_reqack = 0;
        if (is_dm) dm_valid = 0; else if_valid = 0;
        #1;
        checks++;
        if ({if_accept, dm_accept} !== (is_dm ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL accept_pulse: got %b expected %b", {if_accept, dm_accept}, (is_dm ? 2'b01 : 2'b10));
        end
        checks++;
        if ({bus_reqcyc, bus_req, bus_reqtag} !== '0) begin
            errors++; $display("FAIL req_cleared: got cyc=%b req=%h tag=%h expected 0", bus_reqcyc, bus_req, bus_reqtag);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({if_accept, dm_accept} !== 2'b00) begin
            errors++; $display("FAIL accept_single: got %b expected 00", {if_accept, dm_accept});
        end
    endtask

    // Drives n beats of base*(beat+1), then one idle cycle that closes the burst.
    task automatic burst(input bit is_dm, input int n, input logic [DW-1:0] base);
        logic [DW-1:0] d;
        logic [1:0]    exp_v;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            d = base * DW'(i + 1);
            bus_respcyc = 1; bus_resp = d;
            #1;
            exp_v = is_dm ? 2'b01 : 2'b10;
            checks++;
            if ({if_rvalid, dm_rvalid} !== exp_v) begin
                errors++; $display("FAIL rvalid beat%0d: got %b expected %b", i, {if_rvalid, dm_rvalid}, exp_v);
            end
            checks++;
            if (rdata !== d) begin
                errors++; $display("FAIL rdata beat%0d: got %h expected %h", i, rdata, d);
            end
            checks++;
            if ({if_rlast, dm_rlast} !== ((i == BEATS - 1) ? exp_v : 2'b00)) begin
                errors++; $display("FAIL rlast beat%0d: got %b expected %b", i, {if_rlast, dm_rlast},
                                   ((i == BEATS - 1) ? exp_v : 2'b00));
            end
            checks++;
            if (bus_respack !== 1'b1) begin
                errors++; $display("FAIL respack beat%0d: got %b expected 1", i, bus_respack);
            end
        end
        @(negedge clk);
        bus_respcyc = 0; bus_resp = '0;
        #1;
        checks++;
        if ({if_rvalid, dm_rvalid, bus_respack} !== 3'b000) begin
            errors++; $display("FAIL burst_end: got rvalid=%b respack=%b expected 0", {if_rvalid, dm_rvalid}, bus_respack);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        if_valid = 1; dm_valid = 1; if_addr = 64'hAAAA; bus_respcyc = 1; bus_resp = 64'hFFFF; bus_reqack = 1;
        @(negedge clk);
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outputs());
        end
        clear_inputs();
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++; $display("FAIL reset_release: got %h expected 0", all_outputs());
        end
    endtask

    task automatic test_request();
        @(negedge clk);
        if_valid = 1; if_addr = 64'h1000; if_tag = 13'h1100;
        #1;
        checks++;
        if (bus_reqcyc !== 1'b0) begin
            errors++; $display("FAIL req_latency: got %b expected 0", bus_reqcyc);
        end
        req_phase(0, 64'h1000, 13'h1100, 5);
    endtask

    task automatic test_burst();
        burst(0, 8, 64'h11);
    endtask

    task automatic test_tie();
        do_reset();
        @(negedge clk);
        if_valid = 1; if_addr = 64'hA000; if_tag = 13'h0A0;
        dm_valid = 1; dm_addr = 64'hB000; dm_tag = 13'h0B0;
        #1;
        checks++;
        if (bus_reqcyc !== 1'b0) begin
            errors++; $display("FAIL tie_latency: got %b expected 0", bus_reqcyc);
        end
        req_phase(1, 64'hB000, 13'h0B0, 2);
        dm_valid = 1; dm_addr = 64'hC000; dm_tag = 13'h0C0;
        burst(1, 8, 64'h21);
`ifdef SYSBUS_ARB_RR_EN
        req_phase(0, 64'hA000, 13'h0A0, 1);
        burst(0, 8, 64'h31);
        req_phase(1, 64'hC000, 13'h0C0, 1);
        burst(1, 8, 64'h41);
`else
        req_phase(1, 64'hC000, 13'h0C0, 1);
        burst(1, 8, 64'h41);
        req_phase(0, 64'hA000, 13'h0A0, 1);
        burst(0, 8, 64'h31);
`endif
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        dm_valid = 1; dm_addr = 64'h2000; dm_tag = 13'h0ABC;
        req_phase(1, 64'h2000, 13'h0ABC, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_respcyc = 1; bus_resp = 64'h500 + DW'(i);
            #1;
            checks++;
            if (dm_rvalid !== 1'b1) begin
                errors++; $display("FAIL mid_rvalid beat%0d: got %b expected 1", i, dm_rvalid);
            end
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h expected 0", all_outputs());
        end
        @(negedge clk);
        bus_respcyc = 0; bus_resp = '0;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            errors++; $display("FAIL mid_reset_idle: got %h expected 0", all_outputs());
        end
        @(negedge clk);
        dm_valid = 1; dm_addr = 64'h3000; dm_tag = 13'h0123;
        req_phase(1, 64'h3000, 13'h0123, 2);
        burst(1, 8, 64'h101);
    endtask

    task automatic test_short();
        @(negedge clk);
        if_valid = 1; if_addr = 64'h4000; if_tag = 13'h0044;
        req_phase(0, 64'h4000, 13'h0044, 1);
        burst(0, 4, 64'h1234);
        @(negedge clk);
        dm_valid = 1; dm_addr = 64'h5000; dm_tag = 13'h0055;
        #1;
        checks++;
        if (bus_reqcyc !== 1'b0) begin
            errors++; $display("FAIL short_idle: got %b expected 0", bus_reqcyc);
        end
        req_phase(1, 64'h5000, 13'h0055, 3);
        burst(1, 10, 64'h7);
    endtask

    task automatic test_spurious();
        @(negedge clk);
        bus_respcyc = 1; bus_resp = 64'hDEAD; bus_reqack = 1;
        #1;
        checks++;
        if ({if_rvalid, dm_rvalid, bus_respack, rdata} !== '0) begin
            errors++; $display("FAIL idle_respcyc: got rvalid=%b respack=%b rdata=%h expected 0",
                               {if_rvalid, dm_rvalid}, bus_respack, rdata);
        end
        @(negedge clk);
        bus_respcyc = 0; bus_resp = '0; bus_reqack = 0;
        #1;
        checks++;
        if ({if_accept, dm_accept, bus_reqcyc} !== 3'b000) begin
            errors++; $display("FAIL idle_reqack: got accept=%b reqcyc=%b expected 0", {if_accept, dm_accept}, bus_reqcyc);
        end
        if_valid = 1; if_addr = 64'h6000; if_tag = 13'h0066;
        @(negedge clk);
        bus_respcyc = 1; bus_resp = 64'hBEEF;
        #1;
        checks++;
        if ({if_rvalid, dm_rvalid, bus_respack, bus_reqcyc} !== 4'b0001) begin
            errors++; $display("FAIL req_respcyc: got rvalid=%b respack=%b reqcyc=%b expected 00 0 1",
                               {if_rvalid, dm_rvalid}, bus_respack, bus_reqcyc);
        end
        bus_respcyc = 0; bus_resp = '0;
        req_phase(0, 64'h6000, 13'h0066, 1);
        @(negedge clk);
        bus_reqack = 1;
        @(negedge clk);
        bus_reqack = 0;
        #1;
        checks++;
        if ({if_accept, dm_accept, bus_reqcyc} !== 3'b000) begin
            errors++; $display("FAIL wait_reqack: got accept=%b reqcyc=%b expected 0", {if_accept, dm_accept}, bus_reqcyc);
        end
        burst(0, 8, 64'h3);
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_request();
        test_burst();
        test_tie();
        test_reset_mid();
        test_short();
        test_spurious();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
